// File: rtl/tube_scan_driver.sv
// Time-multiplexed 8-digit hex driver: two 4-digit groups share one select phase,
// with a frame-latched shadow of the display value so a scan never mixes two values.
module tube_scan_driver #(
   parameter int CLK_DIV   = 50000,
   parameter int BLANK_CYC = 500,
   parameter int BLANK_LZ  = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] value,
   input  logic        enable,
   output logic [6:0]  digital_tubes,
   output logic [6:0]  digital_tubes2,
   output logic [7:0]  digital_sel,
   output logic        frame_start
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   function automatic logic [6:0] seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
      return s;
   endfunction

   logic [CW-1:0] div_cnt_q;
   logic [1:0]    slot_q;
   logic [31:0]   shadow_q;
   logic          first_q;

   logic       wrap;
   logic       sel_on;
   logic [3:0] lo_nib, hi_nib;
   logic [3:0] one_hot;
   logic       lo_show, hi_show;
   logic [6:0] lo_seg_d, hi_seg_d;

   always_comb begin
      wrap     = (int'(div_cnt_q) == CLK_DIV - 1);
      sel_on   = (int'(div_cnt_q) >= BLANK_CYC);
      lo_nib   = shadow_q[{slot_q, 2'b00} +: 4];
      hi_nib   = shadow_q[{1'b1, slot_q, 2'b00} +: 4];
      one_hot  = 4'b0001 << slot_q;
      // A digit is a leading zero when it and every digit above it are zero.
      lo_show  = (slot_q == 2'd0) || (|(shadow_q >> {slot_q, 2'b00}));
      hi_show  = |(shadow_q >> {1'b1, slot_q, 2'b00});
      lo_seg_d = ((BLANK_LZ != 0) && !lo_show) ? 7'h00 : seg(lo_nib);
      hi_seg_d = ((BLANK_LZ != 0) && !hi_show) ? 7'h00 : seg(hi_nib);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt_q      <= '0;
         slot_q         <= 2'd0;
         shadow_q       <= 32'h0;
         first_q        <= 1'b1;
         digital_tubes  <= 7'h00;
         digital_tubes2 <= 7'h00;
         digital_sel    <= 8'h00;
         frame_start    <= 1'b0;
      end else if (enable) begin
         frame_start <= 1'b0;
         if (first_q) begin
            // First enabled cycle after reset loads the shadow; counters already sit at slot 0.
            first_q        <= 1'b0;
            shadow_q       <= value;
            frame_start    <= 1'b1;
            digital_tubes  <= 7'h00;
            digital_tubes2 <= 7'h00;
            digital_sel    <= 8'h00;
         end else begin
            digital_tubes  <= lo_seg_d;
            digital_tubes2 <= hi_seg_d;
            digital_sel    <= sel_on ? {one_hot, one_hot} : 8'h00;
            if (wrap) begin
               div_cnt_q <= '0;
               slot_q    <= slot_q + 2'd1;
               if (slot_q == 2'd3) begin
                  shadow_q    <= value;
                  frame_start <= 1'b1;
               end
            end else begin
               div_cnt_q <= div_cnt_q + 1'b1;
            end
         end
      end else begin
         digital_tubes  <= 7'h00;
         digital_tubes2 <= 7'h00;
         digital_sel    <= 8'h00;
         frame_start    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tube_scan_driver.sv
// Bench for tube_scan_driver: two instances (leading-zero blanking off/on) checked every
// cycle against a frame-position model, plus directed scenarios and randomized traffic.
module tb_tube_scan_driver;

   localparam int CLK_DIV   = 4;
   localparam int BLANK_CYC = 1;
   localparam int FRAME     = 4 * CLK_DIV;

   logic        clk;
   logic        reset;
   logic [31:0] value;
   logic        enable;
   logic [6:0]  tubes0, tubes2_0, tubes1, tubes2_1;
   logic [7:0]  sel0, sel1;
   logic        fs0, fs1;

   int n_checks = 0;
   int n_pass   = 0;

   logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Model state: position inside the 16-cycle frame and the latched value.
   bit          m_started;
   int          m_pos;
   logic [31:0] m_shadow;

   tube_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC), .BLANK_LZ(0)) u_plain (
      .clk(clk), .reset(reset), .value(value), .enable(enable),
      .digital_tubes(tubes0), .digital_tubes2(tubes2_0), .digital_sel(sel0), .frame_start(fs0));

   tube_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC), .BLANK_LZ(1)) u_lz (
      .clk(clk), .reset(reset), .value(value), .enable(enable),
      .digital_tubes(tubes1), .digital_tubes2(tubes2_1), .digital_sel(sel1), .frame_start(fs1));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [3:0] nib(input logic [31:0] v, input int p);
      return 4'((v >> (4 * p)) & 32'hF);
   endfunction

   task automatic model_reset();
      m_started = 1'b0;
      m_pos     = 0;
      m_shadow  = 32'h0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sel"},  {24'h0, sel0},  32'h0);
      check({tag, "_t"},    {25'h0, tubes0}, 32'h0);
      check({tag, "_t2"},   {25'h0, tubes2_0}, 32'h0);
      check({tag, "_fs"},   {31'h0, fs0},   32'h0);
      check({tag, "_lzsel"}, {24'h0, sel1}, 32'h0);
      check({tag, "_lzt"},  {25'h0, tubes1}, 32'h0);
   endtask

   // One clock: predict outputs from the pre-edge model state and inputs, then compare.
   task automatic tick();
      logic [7:0] es;
      logic [6:0] et, et2, elt, elt2;
      logic       efs;
      int k, c;
      es = 8'h00; et = 7'h00; et2 = 7'h00; elt = 7'h00; elt2 = 7'h00; efs = 1'b0;
      if (enable) begin
         if (!m_started) begin
            m_started = 1'b1;
            m_shadow  = value;
            m_pos     = 0;
            efs       = 1'b1;
         end else begin
            k    = m_pos / CLK_DIV;
            c    = m_pos % CLK_DIV;
            es   = (c >= BLANK_CYC) ? 8'((1 << k) | (1 << (k + 4))) : 8'h00;
            et   = SEG[nib(m_shadow, k)];
            et2  = SEG[nib(m_shadow, k + 4)];
            elt  = (k == 0 || (m_shadow >> (4 * k)) != 0) ? et : 7'h00;
            elt2 = ((m_shadow >> (4 * (k + 4))) != 0) ? et2 : 7'h00;
            m_pos = (m_pos + 1) % FRAME;
            if (m_pos == 0) begin
               m_shadow = value;
               efs      = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      check("sel",    {24'h0, sel0},     {24'h0, es});
      check("tubes",  {25'h0, tubes0},   {25'h0, et});
      check("tubes2", {25'h0, tubes2_0}, {25'h0, et2});
      check("fs",     {31'h0, fs0},      {31'h0, efs});
      check("lz_sel",    {24'h0, sel1},     {24'h0, es});
      check("lz_tubes",  {25'h0, tubes1},   {25'h0, elt});
      check("lz_tubes2", {25'h0, tubes2_1}, {25'h0, elt2});
      check("lz_fs",     {31'h0, fs1},      {31'h0, efs});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic async_reset(input string tag);
      #4;
      reset = 1'b1;
      #1;
      check_all_zero(tag);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      value  = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("por");
      reset  = 1'b0;

      // Scan some data, then reset mid-slot.
      enable = 1'b1;
      value  = 32'hFFFF_FFFF;
      run(7);
      async_reset("midrst");

      // First enabled cycle is a frame start, then slot 0 after one blank cycle.
      value = 32'h1907_1110;
      tick();
      check("first_fs", {31'h0, fs0}, 32'h1);
      tick();
      check("slot0_blank", {24'h0, sel0}, 32'h00);
      tick();
      check("slot0_sel", {24'h0, sel0}, 32'h11);
      check("slot0_t",   {25'h0, tubes0}, 32'h3F);
      check("slot0_t2",  {25'h0, tubes2_0}, 32'h07);
      run(14);

      // Mid-frame value change stays invisible until the next frame start.
      value = 32'h0906_1110;
      run(40);

      // Leading-zero cases.
      value = 32'h0000_00A0;
      run(40);
      value = 32'h0;
      run(40);

      // Freeze in slot 2 mid-slot, then resume without a frame start.
      value = 32'h1357_9BDF;
      for (int i = 0; i < 2 * FRAME && !(m_started && m_pos == 2 * CLK_DIV + 2); i++) tick();
      check("reach_slot2", m_pos, 2 * CLK_DIV + 2);
      enable = 1'b0;
      run(10);
      enable = 1'b1;
      tick();
      check("resume_fs", {31'h0, fs0}, 32'h0);
      run(20);

      // Full segment table sweep.
      value = 32'h89AB_CDEF;
      run(36);
      value = 32'h0123_4567;
      run(36);

      // Randomized traffic: value churn, enable gaps, occasional async reset.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
               0: value = $urandom;
               1: value = $urandom & 32'h0000_0FFF;
               default: value = 32'h1 << ($urandom_range(0, 7) * 4);
            endcase
         end
         enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 119) == 0) async_reset("rnd_rst");
         else tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
